// File: rtl/program_loader.sv
// program_loader: boot-time instruction-memory writer.
// Parses a framed byte stream (SYNC, N lo, N hi, N x {lo, hi}, CK), writes
// 16-bit words to consecutive even addresses and releases the CPU only after
// a complete image whose byte sum (excluding SYNC) is zero mod 256.
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_run,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_D_LO, S_D_HI, S_CKSUM, S_DONE, S_ERR
  } state_t;

  // 17 bits so a 16-bit length can be compared without truncating the limit
  localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

  state_t      r_state, w_next;
  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [7:0]  r_sum;
  logic [7:0]  r_lo;

  logic        w_fire;
  logic [15:0] w_len;
  logic [7:0]  w_sum_nxt;
  logic        w_oversize;
  logic        w_last;
  logic        w_sync;

  assign w_fire     = in_valid && in_ready;
  assign w_len      = {in_data, r_len[7:0]};
  assign w_sum_nxt  = r_sum + in_data;
  assign w_oversize = {1'b0, w_len} > LP_MAX;
  assign w_last     = (r_idx + 16'd1) == r_len;
  assign w_sync     = in_data == SYNC;

  // Only DONE refuses bytes; every other state takes one per cycle
  assign in_ready = (r_state != S_DONE);
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);

  // State register
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state: the machine advances only on an accepted byte
  always_comb begin
    w_next = r_state;
    if (w_fire) begin
      unique case (r_state)
        S_IDLE, S_ERR: if (w_sync) w_next = S_LEN_LO;
        S_LEN_LO:      w_next = S_LEN_HI;
        S_LEN_HI: begin
          if (w_oversize)        w_next = S_ERR;
          else if (w_len == '0)  w_next = S_CKSUM;
          else                   w_next = S_D_LO;
        end
        S_D_LO:        w_next = S_D_HI;
        S_D_HI:        w_next = w_last ? S_CKSUM : S_D_LO;
        S_CKSUM:       w_next = (w_sum_nxt == '0) ? S_DONE : S_ERR;
        S_DONE:        w_next = S_DONE;
        default:       w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: length/sum/index tracking plus registered memory port and flags
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      r_len     <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_lo      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (w_fire) begin
        unique case (r_state)
          S_IDLE, S_ERR: begin
            if (w_sync) begin
              r_sum <= '0;
              r_idx <= '0;
              err   <= 1'b0;
            end
          end
          S_LEN_LO: begin
            r_len[7:0] <= in_data;
            r_sum      <= w_sum_nxt;
          end
          S_LEN_HI: begin
            r_len <= w_len;
            r_sum <= w_sum_nxt;
            if (w_oversize) err <= 1'b1;
          end
          S_D_LO: begin
            r_lo  <= in_data;
            r_sum <= w_sum_nxt;
          end
          S_D_HI: begin
            // Word index doubled into a byte offset; 16-bit wrap is intended
            mem_we    <= 1'b1;
            mem_addr  <= BASE_ADDR + {r_idx[14:0], 1'b0};
            mem_wdata <= {in_data, r_lo};
            r_idx     <= r_idx + 16'd1;
            r_sum     <= w_sum_nxt;
          end
          S_CKSUM: begin
            r_sum <= w_sum_nxt;
            if (w_sum_nxt == '0) cpu_run <= 1'b1;
            else                 err     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: per-byte vector table plus hand-written
// sequences for stalls, terminal DONE behaviour and mid-frame reset.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_run, busy, err;
  logic [15:0] mem_addr, mem_wdata;

  program_loader dut (
    .clk(clk), .nRESET(nRESET), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected outputs observed right after the byte is accepted
  typedef struct {
    bit          rst;
    logic [7:0]  b;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        run, er, bz, rdy;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] wq[$];
  logic        prev_we = 1'b0;
  logic [7:0]  good[8] = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // write monitor: logs every strobe and checks it never lasts two cycles
  always @(negedge clk) begin
    if (mem_we) begin
      wq.push_back({mem_addr, mem_wdata});
      chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = mem_we;
  end

  task automatic do_reset(bit check);
    in_valid = 1'b0;
    nRESET = 1'b0;
    #1;
    if (check) begin
      chk("rst_we",    {31'd0, mem_we},   32'd0);
      chk("rst_addr",  {16'd0, mem_addr}, 32'h0000);
      chk("rst_wdata", {16'd0, mem_wdata},32'h0000);
      chk("rst_run",   {31'd0, cpu_run},  32'd0);
      chk("rst_busy",  {31'd0, busy},     32'd0);
      chk("rst_err",   {31'd0, err},      32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk); #1;
    nRESET = 1'b1;
  endtask

  // offer a byte until accepted (bounded); returns #1 after the accepting edge
  task automatic send(logic [7:0] b);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept", {31'd0, ok}, 32'd1);
  endtask

  function automatic vec_t mk(bit rst, logic [7:0] b, logic we, logic [15:0] a,
                              logic [15:0] d, logic run, logic er, logic bz, logic rdy);
    vec_t v;
    v.rst = rst; v.b = b; v.we = we; v.addr = a; v.wd = d;
    v.run = run; v.er = er; v.bz = bz; v.rdy = rdy;
    return v;
  endfunction

  initial begin
    // good-frame layout, bad CK first, then resend
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h02, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h34, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h12, 1, 16'h0000, 16'h1234, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'hCD, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'hAB, 1, 16'h0002, 16'hABCD, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h41, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h02, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h34, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h12, 1, 16'h0000, 16'h1234, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'hCD, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'hAB, 1, 16'h0002, 16'hABCD, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h40, 0, 0, 0, 1, 0, 0, 0));
    // garbage before SYNC, then empty image
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'hFF, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0));
    // oversize length 0x0401, junk in ERR, then SYNC restarts
    tbl.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 8'h04, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'h33, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'hA5, 0, 0, 0, 0, 0, 1, 1));

    @(posedge clk); #1;
    do_reset(1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(0);
      send(tbl[i].b);
      chk($sformatf("vec%0d_flags", i),
          {27'd0, mem_we, cpu_run, err, busy, in_ready},
          {27'd0, tbl[i].we, tbl[i].run, tbl[i].er, tbl[i].bz, tbl[i].rdy});
      if (tbl[i].we)
        chk($sformatf("vec%0d_write", i), {mem_addr, mem_wdata}, {tbl[i].addr, tbl[i].wd});
    end

    // same image back-to-back and with random valid gaps
    for (int g = 0; g < 2; g++) begin
      do_reset(0);
      wq.delete();
      foreach (good[k]) begin
        if (g == 1) begin
          int n = $urandom_range(0, 3);
          repeat (n) begin @(posedge clk); #1; end
        end
        send(good[k]);
      end
      @(posedge clk); #1;
      chk($sformatf("run%0d_nwrites", g), wq.size(), 32'd2);
      if (wq.size() == 2) begin
        chk($sformatf("run%0d_w0", g), wq[0], 32'h0000_1234);
        chk($sformatf("run%0d_w1", g), wq[1], 32'h0002_ABCD);
      end
      chk($sformatf("run%0d_cpu_run", g), {31'd0, cpu_run}, 32'd1);
      chk($sformatf("run%0d_ready", g), {31'd0, in_ready}, 32'd0);
    end

    // DONE ignores further traffic
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("done_hold", {29'd0, in_ready, busy, cpu_run}, {29'd0, 1'b0, 1'b0, 1'b1});
    chk("done_nowrite", wq.size(), 32'd2);

    // reset between low and high byte of the second word
    do_reset(0);
    send(8'hA5); send(8'h02); send(8'h00); send(8'h34); send(8'h12); send(8'hCD);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    nRESET = 1'b0;
    #1;
    chk("mid_rst_we",   {31'd0, mem_we},  32'd0);
    chk("mid_rst_busy", {31'd0, busy},    32'd0);
    chk("mid_rst_run",  {31'd0, cpu_run}, 32'd0);
    @(posedge clk); #1;
    nRESET = 1'b1;
    wq.delete();
    foreach (good[k]) send(good[k]);
    @(posedge clk); #1;
    chk("reload_nwrites", wq.size(), 32'd2);
    if (wq.size() == 2) begin
      chk("reload_w0", wq[0], 32'h0000_1234);
      chk("reload_w1", wq[1], 32'h0002_ABCD);
    end
    chk("reload_run", {30'd0, cpu_run, err}, {30'd0, 1'b1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction-memory writer. Receives a framed program image as a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into instruction memory at consecutive even byte addresses, the same addresses the CPU fetch stage reads with `pc += 2`. Holds the CPU in reset via `cpu_run` until a complete image with a correct checksum has been written. Sits between the host/debug byte link and the write port of the instruction memory.

## Interface
- `BASE_ADDR`, 16'h0000: byte address of the first instruction word written.
- `MAX_WORDS`, 1024: largest accepted word count; larger counts are rejected.
- `SYNC`, 8'hA5: frame start byte.

- `clk` in 1: clock.
- `nRESET` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_data` holds a byte.
- `in_ready` out 1: loader accepts a byte this cycle; a transfer occurs when `in_valid && in_ready` at the rising edge.
- `in_data` in 8: stream byte.
- `mem_we` out 1: one-cycle write strobe to instruction memory.
- `mem_addr` out 16: write byte address (always even).
- `mem_wdata` out 16: instruction word.
- `cpu_run` out 1: high means the CPU is released. The top level ANDs it with `nRESET` to form the CPU reset.
- `busy` out 1: a frame is in progress (any state other than IDLE, DONE, ERR).
- `err` out 1: the last frame failed (bad checksum or oversize count).

## Operation
- Frame: `SYNC`, `N[7:0]`, `N[15:8]`, then N words each sent low byte then high byte, then one checksum byte `CK`. Valid when the 8-bit sum of all bytes after `SYNC`, including `CK`, is 0 mod 256.
- States: IDLE, LEN_LO, LEN_HI, D_LO, D_HI, CKSUM, DONE, ERR.
  - IDLE: non-`SYNC` bytes are discarded. `SYNC` goes to LEN_LO, clears `err`, the sum, and the word index.
  - LEN_LO → LEN_HI: latch length low byte, add it to the sum.
  - LEN_HI: latch length high byte and add it to the sum.
    - N > `MAX_WORDS`: go to ERR.
    - N == 0: go to CKSUM.
    - Otherwise: go to D_LO.
  - D_LO: latch the low byte, go to D_HI.
  - D_HI: form `{hi, lo}` and issue a write at `BASE_ADDR + 2*i`, then increment i. When i reaches N go to CKSUM, else go to D_LO.
  - CKSUM: add `CK`.
    - Sum == 0: go to DONE, set `cpu_run`.
    - Otherwise: go to ERR, set `err`.
  - DONE: terminal until `nRESET`. `in_ready` = 0.
  - ERR: `in_ready` = 1. A `SYNC` byte restarts the frame (go to LEN_LO, clear `err`). Other bytes are discarded. `cpu_run` stays 0.
- Every data byte, including both length bytes, is added to the 8-bit running sum modulo 256.
- Address arithmetic is 16-bit and wraps modulo 2^16 with no error.
- Memory writes already performed are not undone on error. `cpu_run` is the only gate.

## Timing
- Reset values:
  - state IDLE
  - `in_ready` 1
  - `mem_we` 0
  - `mem_addr` `BASE_ADDR`
  - `mem_wdata` 0
  - `cpu_run` 0
  - `busy` 0
  - `err` 0
- `in_ready` is 1 in every state except DONE. There are no back-pressure bubbles: a byte can be accepted every cycle.
- `mem_we`, `mem_addr`, and `mem_wdata` are registered.
  - `mem_we` is high for exactly one cycle, the cycle after the high byte is accepted.
  - Address and data are stable during that cycle.
  - Peak rate is one write per 2 cycles.
- `cpu_run` and `err` are registered and update the cycle after the `CK` byte is accepted (or after the oversize length high byte, for `err`).
- An `in_valid` held low between bytes only stalls the machine. There is no timeout.
- `nRESET` asserted mid-frame immediately forces all reset values, including `mem_we` = 0. The partial frame is lost.
- `cpu_run` drops to 0 only on `nRESET`.

## Test plan
- Load N=2 with words 0x1234 and 0xABCD, correct `CK` (0x100 − sum(0x02, 0x00, 0x34, 0x12, 0xCD, 0xAB) & 0xFF). Required: two `mem_we` pulses, at (0x0000, 0x1234) and (0x0002, 0xABCD). `cpu_run` = 1 one cycle after `CK`. `err` = 0.
- Same frame with `CK` off by 1. Required: both writes occur, `err` = 1, `cpu_run` = 0. Then resend the good frame: `err` clears on `SYNC` and `cpu_run` = 1 at the end.
- Garbage bytes 0x00, 0xFF, 0x5A before `SYNC`, then N=0 and `CK` = 0x00. Required: no `mem_we`, `cpu_run` = 1.
- Length N = `MAX_WORDS` + 1 (0x0401). Required: `err` = 1 after the length high byte, no `mem_we`, state ERR with `in_ready` = 1.
- Stream bytes back-to-back, then with random `in_valid` gaps. Required: identical write sequence and addresses in both runs. `in_ready` = 0 once DONE.
- Assert `nRESET` between the low and high bytes of word 1. Required: `mem_we` = 0, `busy` = 0, `cpu_run` = 0 immediately. A subsequent full frame loads correctly starting from `BASE_ADDR`.
